// File: rtl/imuldiv_int_mul_iterative_param_if.sv
// Request/response channel bundle for the iterative multiplier.
// Revision: 1.0
`default_nettype none

interface imuldiv_int_mul_iterative_param_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   mulreq_msg_a;
  logic [WIDTH-1:0]   mulreq_msg_b;
  logic               mul_signed_a;
  logic               mul_signed_b;
  logic               mulreq_val;
  logic               mulreq_rdy;
  logic [2*WIDTH-1:0] mulresp_msg_result;
  logic               mulresp_val;
  logic               mulresp_rdy;

  modport master (
    output mulreq_msg_a, mulreq_msg_b, mul_signed_a, mul_signed_b, mulreq_val, mulresp_rdy,
    input  mulreq_rdy, mulresp_msg_result, mulresp_val
  );

  modport slave (
    input  mulreq_msg_a, mulreq_msg_b, mul_signed_a, mul_signed_b, mulreq_val, mulresp_rdy,
    output mulreq_rdy, mulresp_msg_result, mulresp_val
  );
endinterface

`default_nettype wire

// File: rtl/imuldiv_int_mul_iterative_param.sv
// Iterative radix-2^STEP signed/unsigned multiplier, full 2*WIDTH-bit product.
// Optional early exit on exhausted multiplier: IMULDIV_MUL_EARLY_EXIT_EN. Revision: 1.0
`default_nettype none

module imuldiv_int_mul_iterative_param #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  wire logic                             clk,
  input  wire logic                             reset,
  imuldiv_int_mul_iterative_param_if.slave      mul
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;

  generate
    if (WIDTH < 4 || (WIDTH % STEP) != 0 || !(STEP == 1 || STEP == 2 || STEP == 4)) begin : g_bad_params
      $error("imuldiv_int_mul_iterative_param: illegal WIDTH/STEP combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   a_reg;
  logic [PW-1:0]   result_reg;
  logic [PW-1:0]   partial;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] b_shifted;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [CW-1:0]   counter;
  logic            sign_reg;
  logic            neg_a;
  logic            neg_b;
  logic            accept;
  logic            last;

  // Sign/magnitude split: the most negative value negates to itself, which is its correct unsigned magnitude.
  assign neg_a     = mul.mul_signed_a & mul.mulreq_msg_a[WIDTH-1];
  assign neg_b     = mul.mul_signed_b & mul.mulreq_msg_b[WIDTH-1];
  assign mag_a     = neg_a ? -mul.mulreq_msg_a : mul.mulreq_msg_a;
  assign mag_b     = neg_b ? -mul.mulreq_msg_b : mul.mulreq_msg_b;
  assign partial   = a_reg * PW'(b_reg[STEP-1:0]);
  assign b_shifted = b_reg >> STEP;
  assign accept    = (state == IDLE) && mul.mulreq_val;

`ifdef IMULDIV_MUL_EARLY_EXIT_EN
  assign last = (counter == '0) || (b_shifted == '0);
`else
  assign last = (counter == '0);
`endif

  always_comb begin
    state_next             = state;
    mul.mulreq_rdy         = 1'b0;
    mul.mulresp_val        = 1'b0;
    mul.mulresp_msg_result = sign_reg ? -result_reg : result_reg;
    case (state)
      IDLE: begin
        mul.mulreq_rdy = 1'b1;
        if (mul.mulreq_val) state_next = CALC;
      end
      CALC: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        mul.mulresp_val = 1'b1;
        if (mul.mulresp_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      sign_reg   <= 1'b0;
      counter    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        sign_reg   <= neg_a ^ neg_b;
        a_reg      <= PW'(mag_a);
        b_reg      <= mag_b;
        result_reg <= '0;
        counter    <= CW'(N - 1);
      end else if (state == CALC) begin
        result_reg <= result_reg + partial;
        a_reg      <= a_reg << STEP;
        b_reg      <= b_shifted;
        counter    <= counter - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imuldiv_int_mul_iterative_param.sv
// Randomised self-checking bench for imuldiv_int_mul_iterative_param (32x1, 16x4, 16x2 instances).
// Revision: 1.0
`default_nettype none

module tb_imuldiv_int_mul_iterative_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  imuldiv_int_mul_iterative_param_if #(.WIDTH(32)) m  ();
  imuldiv_int_mul_iterative_param_if #(.WIDTH(16)) m4 ();
  imuldiv_int_mul_iterative_param_if #(.WIDTH(16)) m2 ();

  imuldiv_int_mul_iterative_param #(.WIDTH(32), .STEP(1)) dut32 (.clk(clk), .reset(reset), .mul(m));
  imuldiv_int_mul_iterative_param #(.WIDTH(16), .STEP(4)) dut4  (.clk(clk), .reset(reset), .mul(m4));
  imuldiv_int_mul_iterative_param #(.WIDTH(16), .STEP(2)) dut2  (.clk(clk), .reset(reset), .mul(m2));

  // True product of the interpreted operands, reduced mod 2^(2w).
  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic sa, input logic sb, input int w);
    longint va;
    longint vb;
    logic [63:0] p;
    logic [63:0] mask;
    va = (sa && a[w-1]) ? longint'(a) - (longint'(1) << w) : longint'(a);
    vb = (sb && b[w-1]) ? longint'(b) - (longint'(1) << w) : longint'(b);
    p = 64'(va * vb);
    mask = (w >= 32) ? {64{1'b1}} : ((64'd1 << (2 * w)) - 64'd1);
    return p & mask;
  endfunction

  // Number of CALC cycles expected for a given multiplier operand.
  function automatic int ref_lat(input logic [63:0] b, input logic sb, input int w, input int s);
    logic [63:0] mag;
    int k;
    mag = (sb && b[w-1]) ? ((64'd1 << w) - b) : b;
    k = w / s;
`ifdef IMULDIV_MUL_EARLY_EXIT_EN
    k = 1;
    while (k < w / s && (mag >> (k * s)) != 64'd0) k++;
`endif
    return k;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Starts just after a negedge with dut32 idle; returns at the negedge where the response is visible.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb,
                       output logic [63:0] res, output int lat, output logic rdy_calc);
    m.mulreq_msg_a = a;
    m.mulreq_msg_b = b;
    m.mul_signed_a = sa;
    m.mul_signed_b = sb;
    m.mulreq_val   = 1'b1;
    @(negedge clk);
    m.mulreq_val   = 1'b0;
    m.mulreq_msg_a = $urandom;
    m.mulreq_msg_b = $urandom;
    m.mul_signed_a = ~sa;
    rdy_calc = m.mulreq_rdy;
    lat = 0;
    while (!m.mulresp_val && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    res = m.mulresp_msg_result;
  endtask

  task automatic check_op32(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic sa, input logic sb, input logic [63:0] exp_res);
    logic [63:0] res;
    int lat;
    int exp_lat;
    logic rdy_calc;
    exp_lat = ref_lat(64'(b), sb, 32, 1);
    run32(a, b, sa, sb, res, lat, rdy_calc);
    checks += 3;
    if (res !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %h expected %h (a=%h b=%h sa=%0d sb=%0d)", name, res, exp_res, a, b, sa, sb);
    end
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    if (rdy_calc !== 1'b0) begin
      errors++;
      $display("FAIL %s mulreq_rdy in CALC: got %b expected 0", name, rdy_calc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (m.mulreq_rdy !== 1'b1) begin errors++; $display("FAIL reset mulreq_rdy: got %b expected 1", m.mulreq_rdy); end
    if (m.mulresp_val !== 1'b0) begin errors++; $display("FAIL reset mulresp_val: got %b expected 0", m.mulresp_val); end
    if (m.mulresp_msg_result !== 64'h0) begin errors++; $display("FAIL reset result: got %h expected 0", m.mulresp_msg_result); end
  endtask

  task automatic test_directed();
    check_op32("ones_unsigned", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001);
    check_op32("neg3_times_5",  32'hFFFF_FFFD, 32'd5,        1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF1);
    check_op32("minneg_sq",     32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
    check_op32("neg3_neg7",     32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b1, 1'b1, 64'd21);
    check_op32("b_zero",        32'h1234_5678, 32'd0,        1'b0, 1'b0, 64'd0);
    check_op32("b_three",       32'h0000_0007, 32'd3,        1'b0, 1'b0, 64'd21);
    check_op32("b_msb_unsigned",32'h0000_0003, 32'h8000_0000, 1'b0, 1'b0, 64'h1_8000_0000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic sa;
      logic sb;
      a  = pick32();
      b  = pick32();
      sa = 1'($urandom);
      sb = 1'($urandom);
      check_op32("random32", a, b, sa, sb, ref_mul(64'(a), 64'(b), sa, sb, 32));
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] res;
    logic [63:0] exp_res;
    int lat;
    logic rdy_calc;
    logic [31:0] na;
    logic [31:0] nb;
    exp_res = ref_mul(64'h0000_0000_DEAD_BEEF, 64'h0000_0000_8765_4321, 1'b1, 1'b0, 32);
    m.mulresp_rdy = 1'b0;
    run32(32'hDEAD_BEEF, 32'h8765_4321, 1'b1, 1'b0, res, lat, rdy_calc);
    na = 32'hFFFF_FFF0;
    nb = 32'h0000_0011;
    m.mulreq_msg_a = na;
    m.mulreq_msg_b = nb;
    m.mul_signed_a = 1'b1;
    m.mul_signed_b = 1'b1;
    m.mulreq_val   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m.mulresp_val !== 1'b1 || m.mulreq_rdy !== 1'b0 || m.mulresp_msg_result !== exp_res) begin
        errors++;
        $display("FAIL stall cycle %0d: val=%b rdy=%b result=%h expected val=1 rdy=0 result=%h",
                 i, m.mulresp_val, m.mulreq_rdy, m.mulresp_msg_result, exp_res);
      end
      @(negedge clk);
    end
    m.mulresp_rdy = 1'b1;
    checks++;
    if (m.mulreq_rdy !== 1'b0) begin errors++; $display("FAIL handshake cycle mulreq_rdy: got %b expected 0", m.mulreq_rdy); end
    @(negedge clk);
    checks++;
    if (m.mulreq_rdy !== 1'b1 || m.mulresp_val !== 1'b0) begin
      errors++;
      $display("FAIL after handshake: rdy=%b val=%b expected rdy=1 val=0", m.mulreq_rdy, m.mulresp_val);
    end
    check_op32("back_to_back", na, nb, 1'b1, 1'b1, ref_mul(64'(na), 64'(nb), 1'b1, 1'b1, 32));
  endtask

  task automatic test_reset_mid();
    int seen;
    m.mulreq_msg_a = 32'h0000_1111;
    m.mulreq_msg_b = 32'hFFFF_FFFF;
    m.mul_signed_a = 1'b0;
    m.mul_signed_b = 1'b0;
    m.mulreq_val   = 1'b1;
    @(negedge clk);
    m.mulreq_val = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (m.mulreq_rdy !== 1'b1 || m.mulresp_val !== 1'b0 || m.mulresp_msg_result !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset state: rdy=%b val=%b result=%h expected rdy=1 val=0 result=0",
               m.mulreq_rdy, m.mulresp_val, m.mulresp_msg_result);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (m.mulresp_val) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_reset spurious response: got %0d cycles expected 0", seen); end
    check_op32("after_reset", 32'h0000_1111, 32'd9, 1'b0, 1'b0, 64'h9999);
  endtask

  task automatic test_radix();
    for (int i = 0; i < 31; i++) begin
      logic [15:0] a;
      logic [15:0] b;
      logic sa;
      logic sb;
      logic [63:0] exp_res;
      logic [31:0] r4;
      logic [31:0] r2;
      int l4;
      int l2;
      int t;
      logic got4;
      logic got2;
      if (i == 0) begin
        a = 16'h1234; b = 16'hABCD; sa = 1'b0; sb = 1'b0;
      end else begin
        a = 16'($urandom); b = (i % 5 == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
        sa = 1'($urandom); sb = 1'($urandom);
      end
      exp_res = (i == 0) ? 64'h0C37_4FA4 : ref_mul(64'(a), 64'(b), sa, sb, 16);
      m4.mulreq_msg_a = a; m4.mulreq_msg_b = b; m4.mul_signed_a = sa; m4.mul_signed_b = sb;
      m2.mulreq_msg_a = a; m2.mulreq_msg_b = b; m2.mul_signed_a = sa; m2.mul_signed_b = sb;
      m4.mulreq_val = 1'b1;
      m2.mulreq_val = 1'b1;
      @(negedge clk);
      m4.mulreq_val = 1'b0;
      m2.mulreq_val = 1'b0;
      t = 0; got4 = 1'b0; got2 = 1'b0; l4 = -1; l2 = -1; r4 = '0; r2 = '0;
      while (!(got4 && got2) && t < 100) begin
        if (!got4 && m4.mulresp_val) begin got4 = 1'b1; l4 = t; r4 = m4.mulresp_msg_result; end
        if (!got2 && m2.mulresp_val) begin got2 = 1'b1; l2 = t; r2 = m2.mulresp_msg_result; end
        if (!(got4 && got2)) begin
          @(negedge clk);
          t++;
        end
      end
      @(negedge clk);
      checks += 4;
      if (64'(r4) !== exp_res) begin errors++; $display("FAIL step4 result: got %h expected %h", r4, exp_res); end
      if (64'(r2) !== exp_res) begin errors++; $display("FAIL step2 result: got %h expected %h", r2, exp_res); end
      if (l4 !== ref_lat(64'(b), sb, 16, 4)) begin
        errors++; $display("FAIL step4 latency: got %0d expected %0d", l4, ref_lat(64'(b), sb, 16, 4));
      end
      if (l2 !== ref_lat(64'(b), sb, 16, 2)) begin
        errors++; $display("FAIL step2 latency: got %0d expected %0d", l2, ref_lat(64'(b), sb, 16, 2));
      end
    end
  endtask

  initial begin
    m.mulreq_msg_a  = '0; m.mulreq_msg_b  = '0; m.mul_signed_a  = 1'b0; m.mul_signed_b  = 1'b0;
    m.mulreq_val    = 1'b0; m.mulresp_rdy  = 1'b1;
    m4.mulreq_msg_a = '0; m4.mulreq_msg_b = '0; m4.mul_signed_a = 1'b0; m4.mul_signed_b = 1'b0;
    m4.mulreq_val   = 1'b0; m4.mulresp_rdy = 1'b1;
    m2.mulreq_msg_a = '0; m2.mulreq_msg_b = '0; m2.mul_signed_a = 1'b0; m2.mul_signed_b = 1'b0;
    m2.mulreq_val   = 1'b0; m2.mulresp_rdy = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_radix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
